servo_pwm_gen: RTL and testbench

Consumer end of the steering value path. Takes a servo pulse-width command in microseconds and clamps it to a safe window. Slews the applied width toward the command by a bounded step per frame. Generates the 50 Hz servo PWM output pin on the Basys3. Sits after the steering limiter and drives the servo directly.

---
 rtl/servo_pwm_gen_pkg.sv | 12 +
 rtl/servo_pwm_gen_us_tick_gen.sv | 28 ++
 rtl/servo_pwm_gen.sv | 121 ++++++++++++
 tb/tb_servo_pwm_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/servo_pwm_gen_pkg.sv
// Shared constants and types for the servo pulse-width path.
package servo_pkg;

  localparam int unsigned SERVO_W         = 11;
  localparam int unsigned SERVO_MIN_US    = 1000;
  localparam int unsigned SERVO_MAX_US    = 2000;
  localparam int unsigned SERVO_CENTER_US = 1500;
  localparam int unsigned SERVO_PERIOD_US = 20000;

  typedef logic [SERVO_W-1:0] servo_us_t;

endpackage

// File: rtl/servo_pwm_gen_us_tick_gen.sv
// Microsecond tick prescaler: us_tick marks the last clk of every microsecond.
module us_tick_gen #(
  parameter int unsigned CLKS_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick
);

  localparam int unsigned CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] tick_cnt_q;

  assign us_tick = (tick_cnt_q == LAST);

  // Count 0..CLKS_PER_US-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (us_tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// 50 Hz servo PWM generator with command clamp and per-frame slew limit.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned PERIOD_US   = SERVO_PERIOD_US,
  parameter int unsigned MIN_US      = SERVO_MIN_US,
  parameter int unsigned MAX_US      = SERVO_MAX_US,
  parameter int unsigned RESET_US    = SERVO_CENTER_US,
  parameter int unsigned MAX_STEP_US = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SERVO_W-1:0] width_us,
  input  logic               width_valid,
  output logic               pwm_out,
  output logic               frame_start,
  output logic [SERVO_W-1:0] width_applied
);

  localparam int unsigned CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned CNT_W       = 15;

  localparam logic [CNT_W-1:0] US_LAST = CNT_W'(PERIOD_US - 1);
  localparam servo_us_t        MIN_W   = servo_us_t'(MIN_US);
  localparam servo_us_t        MAX_W   = servo_us_t'(MAX_US);
  localparam servo_us_t        RESET_W = servo_us_t'(RESET_US);
  localparam servo_us_t        STEP_W  = servo_us_t'(MAX_STEP_US);

  if (!(MIN_US <= RESET_US && RESET_US <= MAX_US && MAX_US < PERIOD_US &&
        MAX_US < 2048 && (CLK_FREQ_HZ % 1_000_000) == 0)) begin : g_param_check
    $fatal(1, "servo_pwm_gen: illegal parameter set");
  end

  logic                    us_tick;
  logic                    frame_end;
  logic [CNT_W-1:0]        us_cnt_q, us_cnt_d;
  logic                    origin_q;
  logic                    frame_start_q;
  logic                    pwm_q;
  servo_us_t               applied_q, applied_d;
  servo_us_t               target_q, target_d;
  logic signed [SERVO_W:0] diff;
  servo_us_t               abs_diff;

  us_tick_gen #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_us_tick (
    .clk    (clk),
    .rst    (rst),
    .us_tick(us_tick)
  );

  assign frame_end = us_tick && (us_cnt_q == US_LAST);

  // Microsecond position within the frame.
  always_comb begin
    us_cnt_d = us_cnt_q;
    if (frame_end) begin
      us_cnt_d = '0;
    end else if (us_tick) begin
      us_cnt_d = us_cnt_q + CNT_W'(1);
    end
  end

  // Clamp a new command into the safe window; the last strobe of a frame wins.
  always_comb begin
    target_d = target_q;
    if (width_valid) begin
      if (width_us < MIN_W) begin
        target_d = MIN_W;
      end else if (width_us > MAX_W) begin
        target_d = MAX_W;
      end else begin
        target_d = width_us;
      end
    end
  end

  // Slew the applied width toward the target, only at the frame boundary.
  always_comb begin
    diff      = $signed({1'b0, target_q}) - $signed({1'b0, applied_q});
    abs_diff  = diff[SERVO_W] ? servo_us_t'(-diff) : servo_us_t'(diff);
    applied_d = applied_q;
    if (frame_end) begin
      if (MAX_STEP_US == 0 || 32'(abs_diff) <= MAX_STEP_US) begin
        applied_d = target_q;
      end else if (diff[SERVO_W]) begin
        applied_d = applied_q - STEP_W;
      end else begin
        applied_d = applied_q + STEP_W;
      end
    end
  end

  // State and registered outputs. origin_q is high exactly while the prescaler
  // and us counter both sit at zero (after reset or a frame boundary), so the
  // tick counter need not be exported from the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt_q      <= '0;
      origin_q      <= 1'b1;
      frame_start_q <= 1'b0;
      pwm_q         <= 1'b0;
      applied_q     <= RESET_W;
      target_q      <= RESET_W;
    end else begin
      us_cnt_q      <= us_cnt_d;
      origin_q      <= frame_end;
      frame_start_q <= origin_q;
      pwm_q         <= (us_cnt_q < {{(CNT_W-SERVO_W){1'b0}}, applied_q});
      applied_q     <= applied_d;
      target_q      <= target_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign frame_start   = frame_start_q;
  assign width_applied = applied_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Randomized self-checking bench for servo_pwm_gen using a per-frame reference model.
module tb_servo_pwm_gen;

  localparam int CLKS  = 2;
  localparam int PER   = 200;
  localparam int FRAME = PER * CLKS;
  localparam int MINU  = 40;
  localparam int MAXU  = 160;
  localparam int RSTU  = 100;
  localparam int NDUT  = 2;
  localparam int STEP [NDUT] = '{10, 0};

  localparam int NEV = 6;
  localparam int EV_N [NEV] = '{3*FRAME, 6*FRAME+101, 6*FRAME+201,
                                20*FRAME+30, 20*FRAME+230, 33*FRAME};
  localparam int EV_W [NEV] = '{140, 5, 2047, 60, 130, 45};

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] width_us;
  logic        width_valid;
  logic [NDUT-1:0] pwm_s;
  logic [NDUT-1:0] fs_s;
  logic [10:0] wa_s [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  int n;
  int app [NDUT];
  int tgt [NDUT];
  int hi  [NDUT];

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_FREQ_HZ(CLKS * 1_000_000), .PERIOD_US(PER), .MIN_US(MINU),
    .MAX_US(MAXU), .RESET_US(RSTU), .MAX_STEP_US(STEP[0])
  ) dut_slew (
    .clk(clk), .rst(rst), .width_us(width_us), .width_valid(width_valid),
    .pwm_out(pwm_s[0]), .frame_start(fs_s[0]), .width_applied(wa_s[0])
  );

  servo_pwm_gen #(
    .CLK_FREQ_HZ(CLKS * 1_000_000), .PERIOD_US(PER), .MIN_US(MINU),
    .MAX_US(MAXU), .RESET_US(RSTU), .MAX_STEP_US(STEP[1])
  ) dut_noslew (
    .clk(clk), .rst(rst), .width_us(width_us), .width_valid(width_valid),
    .pwm_out(pwm_s[1]), .frame_start(fs_s[1]), .width_applied(wa_s[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  function automatic int clamp(input int w);
    if (w < MINU) return MINU;
    if (w > MAXU) return MAXU;
    return w;
  endfunction

  function automatic int slew(input int cur, input int t, input int step);
    int d;
    d = t - cur;
    if (step == 0 || (d <= step && d >= -step)) return t;
    return (d > 0) ? cur + step : cur - step;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int d = 0; d < NDUT; d++) begin
      app[d] = RSTU;
      tgt[d] = RSTU;
      hi[d]  = 0;
    end
  endtask

  // n counts clock edges since reset release; outputs after edge n describe
  // counter position n-1, and frames begin at positions that are multiples of FRAME.
  task automatic run_cycles(input int ncyc, input bit directed, input int rand_from);
    int w;
    bit v;
    int pos;
    for (int k = 0; k < ncyc; k++) begin
      n++;
      v = 1'b0;
      w = 0;
      if (directed) begin
        for (int e = 0; e < NEV; e++) begin
          if (EV_N[e] == n) begin
            v = 1'b1;
            w = EV_W[e];
          end
        end
      end
      if (!v && n >= rand_from && $urandom_range(0, 299) == 0) begin
        v = 1'b1;
        w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2047))
                                         : int'($urandom_range(30, 170));
      end
      width_valid = v;
      width_us    = 11'(w);
      @(negedge clk);
      pos = (n - 1) % FRAME;
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("pwm_out[%0d]", d), int'(pwm_s[d]), int'((pos / CLKS) < app[d]));
        chk($sformatf("frame_start[%0d]", d), int'(fs_s[d]), int'(pos == 0));
        hi[d] += int'(pwm_s[d]);
        if (pos == FRAME - 1) begin
          chk($sformatf("high_time[%0d]", d), hi[d], app[d] * CLKS);
          hi[d] = 0;
        end
        if (n % FRAME == 0) app[d] = slew(app[d], tgt[d], STEP[d]);
        if (v) tgt[d] = clamp(w);
        chk($sformatf("width_applied[%0d]", d), int'(wa_s[d]), app[d]);
      end
    end
    width_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    width_valid = 1'b0;
    width_us    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_pwm[%0d]", d), int'(pwm_s[d]), 0);
      chk($sformatf("rst_fs[%0d]", d), int'(fs_s[d]), 0);
      chk($sformatf("rst_wa[%0d]", d), int'(wa_s[d]), RSTU);
    end
    rst = 1'b0;

    // Directed commands first, random ones in the final frames; stop mid-pulse.
    run_cycles(40 * FRAME + 60, 1'b1, 34 * FRAME);

    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("midrst_pwm[%0d]", d), int'(pwm_s[d]), 0);
      chk($sformatf("midrst_fs[%0d]", d), int'(fs_s[d]), 0);
      chk($sformatf("midrst_wa[%0d]", d), int'(wa_s[d]), RSTU);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;

    run_cycles(10 * FRAME, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
